// File: rtl/dcache_if.sv
// Pipeline-side and memory-side signals of the 2-way write-through data cache.
// Signal names follow the data-memory and MEM-stage names they connect to.
interface dcache_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Driven side: the pipeline and the data memory around the cache.
  modport master (
    output MEM_R_EN, MEM_W_EN, addr, wdata, mem_rdata,
    input  rdata, ready, mem_r_en, mem_w_en, mem_addr, mem_wdata
  );

  // The cache controller itself.
  modport slave (
    input  MEM_R_EN, MEM_W_EN, addr, wdata, mem_rdata,
    output rdata, ready, mem_r_en, mem_w_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache with one-word lines.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_controller #(
  parameter int          SETS        = 16,
  parameter int          MEM_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ_MEM,
    WRITE_MEM
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mem_r_en;
  logic               r_mem_w_en;
  logic [1:0]         r_valid [SETS];
  logic [SETS-1:0]    r_lru;
  logic [TAG_W-1:0]   r_tag   [2][SETS];
  logic [31:0]        r_data  [2][SETS];

  logic [29:0]        w_word;
  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_hit;
  logic               w_hit_way;
  logic               w_fill_way;
  logic [31:0]        w_hit_data;
  logic               w_wr_req;
  logic               w_rd_req;
  logic               w_rd_hit;
  logic               w_last;
  logic               w_ready;

  assign w_word     = 30'((bus.addr - BASE_ADDR) >> 2);
  assign w_idx      = w_word[IDX_W-1:0];
  assign w_tag      = w_word[29:IDX_W];

  assign w_hit0     = r_valid[w_idx][0] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1     = r_valid[w_idx][1] && (r_tag[1][w_idx] == w_tag);
  assign w_hit      = w_hit0 || w_hit1;
  assign w_hit_way  = w_hit1;
  assign w_fill_way = r_lru[w_idx];
  assign w_hit_data = r_data[w_hit_way][w_idx];

  // A simultaneous read and write request is handled as a write.
  assign w_wr_req   = bus.MEM_W_EN;
  assign w_rd_req   = bus.MEM_R_EN && !bus.MEM_W_EN;
  assign w_rd_hit   = (r_state == IDLE) && w_rd_req && w_hit;
  assign w_last     = (r_cnt == CNT_W'(MEM_LATENCY - 1));

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      IDLE:      w_ready = !w_wr_req && (!w_rd_req || w_hit);
      READ_MEM:  w_ready = 1'b0;
      WRITE_MEM: w_ready = w_last;
      default:   w_ready = 1'b0;
    endcase
  end

  assign bus.ready     = w_ready;
  assign bus.rdata     = w_rd_hit ? w_hit_data : 32'd0;
  assign bus.mem_r_en  = r_mem_r_en;
  assign bus.mem_w_en  = r_mem_w_en;
  assign bus.mem_addr  = bus.addr;
  assign bus.mem_wdata = bus.wdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_lru      <= '0;
      for (int s = 0; s < SETS; s++) r_valid[s] <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_wr_req) begin
            r_state    <= WRITE_MEM;
            r_mem_w_en <= 1'b1;
          end else if (w_rd_req && !w_hit) begin
            r_state    <= READ_MEM;
            r_mem_r_en <= 1'b1;
          end else if (w_rd_hit) begin
            r_lru[w_idx] <= ~w_hit_way;
          end
        end
        READ_MEM: begin
          if (w_last) begin
            r_valid[w_idx][w_fill_way] <= 1'b1;
            r_lru[w_idx]               <= ~w_fill_way;
            r_state                    <= IDLE;
            r_cnt                      <= '0;
            r_mem_r_en                 <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WRITE_MEM: begin
          if (w_last) begin
            if (w_hit) r_lru[w_idx] <= ~w_hit_way;
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mem_w_en <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_cnt      <= '0;
          r_mem_r_en <= 1'b0;
          r_mem_w_en <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: tag and data arrays are not reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (r_state == READ_MEM && w_last) begin
      r_data[w_fill_way][w_idx] <= bus.mem_rdata;
      r_tag[w_fill_way][w_idx]  <= w_tag;
    end else if (r_state == WRITE_MEM && w_last && w_hit) begin
      r_data[w_hit_way][w_idx] <= bus.wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;
  logic        r_fill_done;

  // The IDLE cycle that completes a fill is the tail of a miss, so it is not a hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_fill_done  <= 1'b0;
    end else begin
      r_fill_done <= (r_state == READ_MEM) && w_last;
      if (w_rd_hit && !r_fill_done && (r_hit_count != '1))
        r_hit_count <= r_hit_count + 32'd1;
      if ((r_state == IDLE) && w_rd_req && !w_hit && (r_miss_count != '1))
        r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: the driver queues expected responses,
// a negedge monitor pops and compares each completed request.
module tb_dcache_controller;
  localparam int L = 2;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    int          stall;
    int          ren;
    int          wen;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  int     n_checks = 0;
  int     n_fail   = 0;
  exp_t   sb_q[$];

  logic [31:0] mem     [64];
  bit          written [64];
  logic [5:0]  mem_word;

  dcache_if bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  dcache_controller #(.SETS(16), .MEM_LATENCY(L), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
  );
`else
  dcache_controller #(.SETS(16), .MEM_LATENCY(L), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  // Data-memory model: unwritten word n reads as 0xC0DE0000+n.
  assign mem_word = bus.mem_addr[7:2];
  always_comb begin
    bus.mem_rdata = written[mem_word] ? mem[mem_word] : (32'hC0DE_0000 + 32'(mem_word));
  end
  always @(posedge clk) begin
    if (bus.mem_w_en) begin
      mem[mem_word]     <= bus.mem_wdata;
      written[mem_word] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: accumulates stall and memory-enable cycles, compares when ready completes a request.
  initial begin : monitor
    int st = 0, rn = 0, wn = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        st = 0; rn = 0; wn = 0;
      end else if (bus.MEM_R_EN || bus.MEM_W_EN) begin
        rn += int'(bus.mem_r_en);
        wn += int'(bus.mem_w_en);
        if (!bus.ready) st++;
        else begin
          if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_response: got ready=1 expected no pending request");
          end else begin
            e = sb_q.pop_front();
            check({e.name, "_rdata"}, bus.rdata, e.rdata);
            check({e.name, "_stall"}, 32'(st), 32'(e.stall));
            check({e.name, "_mem_r_en_cycles"}, 32'(rn), 32'(e.ren));
            check({e.name, "_mem_w_en_cycles"}, 32'(wn), 32'(e.wen));
          end
          st = 0; rn = 0; wn = 0;
        end
      end
    end
  end

  task automatic req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                     input string nm, input logic [31:0] er, input int es, input int eren,
                     input int ewen);
    exp_t e;
    bit done = 0;
    e.name = nm; e.rdata = er; e.stall = es; e.ren = eren; e.wen = ewen;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.MEM_W_EN = w; bus.MEM_R_EN = r; bus.addr = a; bus.wdata = d;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.ready) done = 1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no ready within 40 cycles expected ready", nm);
      void'(sb_q.pop_front());
    end
  endtask

  task automatic rd_miss(input logic [31:0] a, input logic [31:0] v, input string nm);
    req(1'b0, 1'b1, a, 32'd0, nm, v, L + 1, L, 0);
  endtask
  task automatic rd_hit(input logic [31:0] a, input logic [31:0] v, input string nm);
    req(1'b0, 1'b1, a, 32'd0, nm, v, 0, 0, 0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
    req(1'b1, 1'b0, a, d, nm, 32'd0, L, 0, L);
  endtask
  task automatic idle();
    @(posedge clk); #1;
    bus.MEM_W_EN = 1'b0; bus.MEM_R_EN = 1'b0;
  endtask
  task automatic do_reset();
    idle();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0; bus.addr = 32'd1024; bus.wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_mem_r_en", 32'(bus.mem_r_en), 32'd0);
    check("reset_mem_w_en", 32'(bus.mem_w_en), 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);

    wr     (32'd1028, 32'h1111_1111, "wr_1028");
    rd_miss(32'd1028, 32'h1111_1111, "rd_1028_no_alloc");
    rd_hit (32'd1028, 32'h1111_1111, "rd_1028_rehit");
    rd_miss(32'd1024, 32'hC0DE_0000, "rd_1024_fill_w0");
    rd_miss(32'd1088, 32'hC0DE_0010, "rd_1088_fill_w1");
    rd_miss(32'd1152, 32'hC0DE_0020, "rd_1152_evict_1024");
    rd_hit (32'd1088, 32'hC0DE_0010, "rd_1088_hit");
    rd_miss(32'd1024, 32'hC0DE_0000, "rd_1024_evicted");
    wr     (32'd1028, 32'hA5A5_A5A5, "wr_1028_hit");
    rd_hit (32'd1028, 32'hA5A5_A5A5, "rd_1028_updated");
    wr     (32'd1032, 32'h2222_2222, "wr_1032_miss");
    rd_miss(32'd1032, 32'h2222_2222, "rd_1032_no_alloc");
    req(1'b1, 1'b1, 32'd1036, 32'h3333_3333, "rw_1036_as_write", 32'd0, L, 0, L);
    rd_miss(32'd1036, 32'h3333_3333, "rd_1036_after_rw");
    idle();

    // Reset during the first READ_MEM cycle of a miss.
    @(posedge clk); #1;
    bus.MEM_R_EN = 1'b1; bus.addr = 32'd1040;
    @(negedge clk);
    @(negedge clk);
    check("inflight_mem_r_en", 32'(bus.mem_r_en), 32'd1);
    #2 rst = 1'b0;
    #1 check("async_reset_mem_r_en", 32'(bus.mem_r_en), 32'd0);
    bus.MEM_R_EN = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd_miss(32'd1028, 32'hA5A5_A5A5, "rd_1028_after_reset");
    rd_hit (32'd1028, 32'hA5A5_A5A5, "rd_1028_after_refill");
    idle();

`ifdef DCACHE_STATS_EN
    do_reset();
    #1;
    check("stats_reset_hits", hit_count, 32'd0);
    check("stats_reset_misses", miss_count, 32'd0);
    rd_miss(32'd1024, 32'hC0DE_0000, "st_miss_1024");
    rd_hit (32'd1024, 32'hC0DE_0000, "st_hit_1024a");
    rd_hit (32'd1024, 32'hC0DE_0000, "st_hit_1024b");
    rd_miss(32'd1028, 32'hA5A5_A5A5, "st_miss_1028");
    rd_hit (32'd1028, 32'hA5A5_A5A5, "st_hit_1028");
    wr     (32'd1028, 32'h4444_4444, "st_wr_1028");
    idle();
    #1;
    check("stats_hits", hit_count, 32'd3);
    check("stats_misses", miss_count, 32'd2);
    do_reset();
    #1;
    check("stats_cleared_hits", hit_count, 32'd0);
    check("stats_cleared_misses", miss_count, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- 2-way set-associative, write-through, no-write-allocate data cache between the MEM-stage pipeline register and the 64-word data memory.
- Hits return read data in the same cycle. Misses and all writes stall the pipeline through ready=0 and drive the memory-side enables for MEM_LATENCY cycles.
- Addresses use the same 1024-based byte map as the data memory.

Parameters:
SETS, 16, number of sets; power of 2, ≥2
MEM_LATENCY, 2, cycles the data memory needs per access; ≥1
BASE_ADDR, 1024, byte address of memory word 0

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets)
MEM_R_EN  input  1  pipeline read request
MEM_W_EN  input  1  pipeline write request
addr  input  32  pipeline byte address
wdata  input  32  pipeline store data
rdata  output  32  load data, valid when ready=1 and MEM_R_EN=1
ready  output  1  0 = freeze pipeline
mem_r_en  output  1  to data memory MEM_R_EN
mem_w_en  output  1  to data memory MEM_W_EN
mem_addr  output  32  to data memory Data_addr; equals addr
mem_wdata  output  32  to data memory Data_in; equals wdata
mem_rdata  input  32  from data memory Data_out

Behaviour:
- Address decode:
  - word address = (addr - BASE_ADDR) >> 2
  - index = word address [log2(SETS)-1:0]
  - tag = word address [29:log2(SETS)]
  - Each line is one 32-bit word with valid, tag and data; each set holds one LRU bit, which points to the way to evict.
- Request priority: if MEM_W_EN and MEM_R_EN are both 1, treat the request as a write.
- FSM states: IDLE, READ_MEM, WRITE_MEM. Counter cnt clears on every state entry and increments each cycle in READ_MEM and WRITE_MEM.
- IDLE:
  - No request: ready=1.
  - Read hit: ready=1, rdata=hit way data (combinational). At the clock edge, LRU is set to the other way.
  - Read miss: ready=0; go to READ_MEM.
  - Write: ready=0; go to WRITE_MEM.
- READ_MEM:
  - Outputs: mem_r_en=1, ready=0.
  - At the edge where cnt==MEM_LATENCY-1:
    - Write mem_rdata into the LRU way: valid=1, tag stored.
    - Flip LRU; go to IDLE.
  - In IDLE the request then hits.
  - Read-miss stall = MEM_LATENCY+1 cycles.
- WRITE_MEM:
  - Outputs: mem_w_en=1.
  - ready=1 only in the cycle where cnt==MEM_LATENCY-1, and the FSM returns to IDLE at that edge.
  - On a tag hit, update that way's data at the same edge and set LRU to the other way. On a miss, the cache is unchanged.
  - Write stall = MEM_LATENCY cycles.
- Other cycles: mem_r_en=mem_w_en=0.
- rdata is 0 when not in a read-hit cycle.
- The pipeline must hold addr/wdata/enables stable while ready=0. Behaviour under changed inputs mid-stall is undefined.
- Reset (rst=0, any state, any cycle):
  - All valid and LRU bits 0, state IDLE, cnt 0.
  - mem_r_en and mem_w_en go 0 immediately.
  - An in-flight fill or write is discarded and does not complete.

Optional Feature:
- DCACHE_STATS_EN:
  - Defined: adds 32-bit outputs hit_count and miss_count, cleared by reset.
    - hit_count increments once per read hit in IDLE.
    - miss_count increments once per read-miss entry into READ_MEM.
    - Writes are not counted. Counters saturate at 0xFFFFFFFF.
  - Undefined: the ports and counters do not exist; the core behaviour is identical.

Test Plan:
- Reset, then write 0x11111111 to 1028 → ready 0 for 1 cycle, then mem_w_en=1 for 2 cycles with ready=1 in the second. No cache allocation: a following read of 1028 misses.
- Read 1028 after the write → mem_r_en=1 for 2 cycles, ready returns 1 on cycle 4 with rdata=0x11111111. An immediate re-read gives ready=1 in the same cycle with mem_r_en=0.
- Read 1024, 1088, 1152 (all set 0), then read 1088 → hit. Then read 1024 → miss, because the LRU way was evicted by 1152.
- With 1028 cached, write 0xA5A5A5A5 to 1028 → then read 1028 hits, returns 0xA5A5A5A5, and mem_r_en stays 0.
- Read-miss in progress: drive rst=0 while cnt=0 → mem_r_en falls with no clock edge. After release, reading previously cached 1028 misses.
- With DCACHE_STATS_EN: sequence of 3 hits and 2 read misses → hit_count=3, miss_count=2. Reset → both 0.
